cmd_arbiter: RTL and testbench

//  Parametrised command arbiter/sequencer. Grants exactly one of N_CH command

---
 rtl/cmd_arbiter_if.sv | 29 ++
 rtl/cmd_arbiter.sv | 118 +++++++++++
 tb/tb_cmd_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_arbiter_if.sv
// Command-source/arbiter bundle: per-channel req/done plus the watchdog limit in,
// grant, sequence number and abort status out.
interface cmd_arbiter_if #(
  parameter int N_CH      = 2,
  parameter int CSN_W     = 32,
  parameter int TIMEOUT_W = 16
);
  localparam int GW = $clog2(N_CH);

  logic [N_CH-1:0]      req;
  logic [N_CH-1:0]      done;
  logic [TIMEOUT_W-1:0] timeout_cycles;
  logic [N_CH-1:0]      run;
  logic [GW-1:0]        grant_id;
  logic                 busy;
  logic [CSN_W-1:0]     csn;
  logic                 timeout_err;
  logic [15:0]          timeout_count;

  modport master (
    output req, done, timeout_cycles,
    input  run, grant_id, busy, csn, timeout_err, timeout_count
  );

  modport slave (
    input  req, done, timeout_cycles,
    output run, grant_id, busy, csn, timeout_err, timeout_count
  );
endinterface

// File: rtl/cmd_arbiter.sv
// Command arbiter: grants one channel until its done or a watchdog abort; req->run is 1 cycle.
// Fixed priority (ch0 highest) by default; define CMD_ARB_ROUND_ROBIN_EN for round-robin.
module cmd_arbiter #(
  parameter int N_CH      = 2,
  parameter int CSN_W     = 32,
  parameter int TIMEOUT_W = 16
) (
  input logic          clk,
  input logic          rst,
  cmd_arbiter_if.slave cmd
);
  localparam int GW = $clog2(N_CH);

  typedef enum logic [1:0] {IDLE, RUN, ABORT} state_t;

  state_t               state;
  logic [N_CH-1:0]      run_q;
  logic [GW-1:0]        gid_q;
  logic                 busy_q;
  logic [CSN_W-1:0]     csn_q;
  logic                 terr_q;
  logic [15:0]          tcnt_q;
  logic [TIMEOUT_W-1:0] wd_q;
  logic [GW-1:0]        winner;
  logic                 expire;

`ifdef CMD_ARB_ROUND_ROBIN_EN
  logic [GW-1:0] ptr_q;
  logic [GW-1:0] ptr_next;
  logic [GW-1:0] rr_idx;

  always_comb ptr_next = (int'(gid_q) == N_CH - 1) ? '0 : gid_q + 1'b1;

  // Walk from the farthest candidate back to ptr so the nearest requester wins.
  always_comb begin
    winner = '0;
    rr_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      rr_idx = GW'((int'(ptr_q) + i) % N_CH);
      if (cmd.req[rr_idx]) winner = rr_idx;
    end
  end
`else
  always_comb begin
    winner = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (cmd.req[i]) winner = GW'(i);
    end
  end
`endif

  // Limit is read live so a mid-grant change applies on the very next compare.
  assign expire = (cmd.timeout_cycles != '0) &&
                  (wd_q == cmd.timeout_cycles - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      run_q  <= '0;
      gid_q  <= '0;
      busy_q <= 1'b0;
      csn_q  <= '0;
      terr_q <= 1'b0;
      tcnt_q <= '0;
      wd_q   <= '0;
`ifdef CMD_ARB_ROUND_ROBIN_EN
      ptr_q  <= '0;
`endif
    end else begin
      terr_q <= 1'b0;
      unique case (state)
        IDLE: begin
          wd_q <= '0;
          if (|cmd.req) begin
            state  <= RUN;
            gid_q  <= winner;
            run_q  <= N_CH'(1) << winner;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          if (wd_q != '1) wd_q <= wd_q + 1'b1;
          if (cmd.done[gid_q]) begin
            state  <= IDLE;
            run_q  <= '0;
            busy_q <= 1'b0;
            csn_q  <= csn_q + 1'b1;
`ifdef CMD_ARB_ROUND_ROBIN_EN
            ptr_q  <= ptr_next;
`endif
          end else if (expire) begin
            state  <= ABORT;
            run_q  <= '0;
            busy_q <= 1'b0;
            terr_q <= 1'b1;
            if (tcnt_q != 16'hFFFF) tcnt_q <= tcnt_q + 16'd1;
`ifdef CMD_ARB_ROUND_ROBIN_EN
            ptr_q  <= ptr_next;
`endif
          end
        end
        ABORT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign cmd.run           = run_q;
  assign cmd.grant_id      = gid_q;
  assign cmd.busy          = busy_q;
  assign cmd.csn           = csn_q;
  assign cmd.timeout_err   = terr_q;
  assign cmd.timeout_count = tcnt_q;
endmodule

// File: tb/tb_cmd_arbiter.sv
// Directed bench for cmd_arbiter: expected grants are queued at stimulus time and popped on run.
module tb_cmd_arbiter;
  localparam int N_CH      = 2;
  localparam int CSN_W     = 32;
  localparam int TIMEOUT_W = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_q[$];

  always #5 clk = ~clk;

  cmd_arbiter_if #(.N_CH(N_CH), .CSN_W(CSN_W), .TIMEOUT_W(TIMEOUT_W)) cmd ();

  cmd_arbiter #(.N_CH(N_CH), .CSN_W(CSN_W), .TIMEOUT_W(TIMEOUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .cmd (cmd.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_run"},  64'(cmd.run), 64'd0);
    chk({tag, "_gid"},  64'(cmd.grant_id), 64'd0);
    chk({tag, "_busy"}, 64'(cmd.busy), 64'd0);
    chk({tag, "_csn"},  64'(cmd.csn), 64'd0);
    chk({tag, "_terr"}, 64'(cmd.timeout_err), 64'd0);
    chk({tag, "_tcnt"}, 64'(cmd.timeout_count), 64'd0);
  endtask

  // Steps until run rises (bounded), then checks it against the oldest queued grant.
  task automatic wait_grant(input string tag, output int lat);
    int ch;
    lat = 0;
    while (cmd.run == '0 && lat < 8) begin
      step();
      lat++;
    end
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: grant run=%0h observed with no expected grant queued", tag, cmd.run);
    end else begin
      ch = exp_q.pop_front();
      chk({tag, "_run"},  64'(cmd.run), 64'd1 << ch);
      chk({tag, "_gid"},  64'(cmd.grant_id), 64'(ch));
      chk({tag, "_busy"}, 64'(cmd.busy), 64'd1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int lat;
    int high_cnt;
    int pulse_cnt;
    logic [15:0] tcnt_at_pulse;

    cmd.req = '0;
    cmd.done = '0;
    cmd.timeout_cycles = '0;

    // Reset values
    rst = 1'b1;
    step();
    step();
    chk_reset("reset");
    rst = 1'b0;
    step();

    // Single command on ch0: 1-cycle latency, done after 5 run cycles
    cmd.req = 2'b01;
    exp_q.push_back(0);
    wait_grant("t1_grant", lat);
    chk("t1_latency", 64'(lat), 64'd1);
    cmd.req = '0;
    repeat (4) step();
    chk("t1_run_hold", 64'(cmd.run), 64'b01);
    cmd.done = 2'b01;
    step();
    cmd.done = '0;
    chk("t1_run_drop", 64'(cmd.run), 64'd0);
    chk("t1_busy_drop", 64'(cmd.busy), 64'd0);
    chk("t1_csn", 64'(cmd.csn), 64'd1);

    // Both channels held: arbitration order and mandatory idle gap
    do_reset();
    cmd.req = 2'b11;
    for (int g = 0; g < 4; g++) begin
`ifdef CMD_ARB_ROUND_ROBIN_EN
      exp_q.push_back(g % 2);
`else
      exp_q.push_back(0);
`endif
      wait_grant($sformatf("t2_grant%0d", g), lat);
      step();
      cmd.done = cmd.run;
      step();
      cmd.done = '0;
      chk($sformatf("t2_idle_gap%0d", g), 64'(cmd.run), 64'd0);
    end
    cmd.req = '0;
    chk("t2_csn", 64'(cmd.csn), 64'd4);

    // done from a non-granted channel is ignored
    step();
    cmd.req = 2'b01;
    exp_q.push_back(0);
    wait_grant("t6_grant", lat);
    cmd.req = '0;
    cmd.done = 2'b10;
    step();
    cmd.done = '0;
    chk("t6_run_stays", 64'(cmd.run), 64'b01);
    chk("t6_csn_same", 64'(cmd.csn), 64'd4);
    cmd.done = 2'b01;
    step();
    cmd.done = '0;
    chk("t6_csn_done", 64'(cmd.csn), 64'd5);

    // Watchdog abort: run[1] high exactly 10 cycles, one error pulse
    cmd.timeout_cycles = 16'd10;
    step();
    cmd.req = 2'b10;
    exp_q.push_back(1);
    wait_grant("t3_grant", lat);
    cmd.req = '0;
    high_cnt = 0;
    pulse_cnt = 0;
    tcnt_at_pulse = '0;
    for (int i = 0; i < 20; i++) begin
      if (cmd.run == 2'b10) high_cnt++;
      if (cmd.timeout_err) begin
        pulse_cnt++;
        tcnt_at_pulse = cmd.timeout_count;
      end
      step();
    end
    chk("t3_run_cycles", 64'(high_cnt), 64'd10);
    chk("t3_err_pulses", 64'(pulse_cnt), 64'd1);
    chk("t3_tcnt_at_pulse", 64'(tcnt_at_pulse), 64'd1);
    chk("t3_tcnt", 64'(cmd.timeout_count), 64'd1);
    chk("t3_csn_same", 64'(cmd.csn), 64'd5);
    chk("t3_busy", 64'(cmd.busy), 64'd0);

    // done in the expiry cycle wins over the abort
    cmd.timeout_cycles = 16'd4;
    cmd.req = 2'b01;
    exp_q.push_back(0);
    wait_grant("t4_grant", lat);
    cmd.req = '0;
    repeat (3) step();
    chk("t4_run_before", 64'(cmd.run), 64'b01);
    cmd.done = 2'b01;
    step();
    cmd.done = '0;
    chk("t4_csn", 64'(cmd.csn), 64'd6);
    chk("t4_terr", 64'(cmd.timeout_err), 64'd0);
    chk("t4_run_drop", 64'(cmd.run), 64'd0);
    step();
    chk("t4_terr_after", 64'(cmd.timeout_err), 64'd0);
    chk("t4_tcnt", 64'(cmd.timeout_count), 64'd1);

    // csn wrap from all-ones
    cmd.timeout_cycles = '0;
    force dut.csn_q = {CSN_W{1'b1}};
    step();
    release dut.csn_q;
    chk("t5_csn_preload", 64'(cmd.csn), 64'(32'hFFFF_FFFF));
    cmd.req = 2'b10;
    exp_q.push_back(1);
    wait_grant("t5_grant", lat);
    cmd.req = '0;
    cmd.done = 2'b10;
    step();
    cmd.done = '0;
    chk("t5_csn_wrap", 64'(cmd.csn), 64'd0);

    // Reset mid-RUN clears everything on the next edge, no done needed
    step();
    cmd.req = 2'b01;
    exp_q.push_back(0);
    wait_grant("t5_grant_rst", lat);
    cmd.req = '0;
    step();
    rst = 1'b1;
    step();
    chk_reset("t5_midrun_rst");
    rst = 1'b0;
    cmd.req = 2'b10;
    exp_q.push_back(1);
    wait_grant("t5_recover", lat);
    chk("t5_recover_latency", 64'(lat), 64'd1);
    cmd.req = '0;
    cmd.done = 2'b10;
    step();
    cmd.done = '0;
    chk("t5_recover_csn", 64'(cmd.csn), 64'd1);

    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
